ya_fifo_rr_drain_arbiter: RTL and testbench

//  Round-robin arbiter that drains N_CH standard (non-FWFT) ya_fifo_module read ports into one

---
 rtl/ya_fifo_rr_drain_arbiter.sv | 206 ++++++++++++++++++++
 tb/tb_ya_fifo_rr_drain_arbiter.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ya_fifo_rr_drain_arbiter.sv
// Round-robin drain of N_CH non-FWFT FIFO read ports into one tagged valid/ready stream.
// Optional per-channel pop counters on o_word_cnt when YA_FIFO_ARB_CNT_EN is defined.
module ya_fifo_rr_drain_arbiter #(
    parameter int N_CH      = 4,
    parameter int WORD_SIZE = 8,
    parameter int BURST_LEN = 4,
    localparam int CH_W     = $clog2(N_CH)
) (
    input  logic                      i_clk,
    input  logic                      i_reset,
    input  logic [N_CH-1:0]           i_fifo_not_empty,
    output logic [N_CH-1:0]           o_fifo_re,
    input  logic [N_CH*WORD_SIZE-1:0] i_fifo_data,
    output logic                      o_valid,
    input  logic                      i_ready,
    output logic [WORD_SIZE-1:0]      o_data,
    output logic [CH_W-1:0]           o_ch,
    output logic                      o_busy
`ifdef YA_FIFO_ARB_CNT_EN
    ,
    output logic [N_CH*16-1:0]        o_word_cnt
`endif
);

    localparam int CNT_W = $clog2(BURST_LEN + 1);

    typedef enum logic {
        ST_IDLE,
        ST_GRANT
    } state_t;

    typedef struct packed {
        logic [CH_W-1:0]      ch;
        logic [WORD_SIZE-1:0] data;
    } entry_t;

    state_t            state_q, state_d;
    logic [CH_W-1:0]   grant_q, grant_d;
    logic [CH_W-1:0]   last_grant_q, last_grant_d;
    logic [CNT_W-1:0]  burst_cnt_q, burst_cnt_d;
    logic              rd_pend_q;
    logic [CH_W-1:0]   rd_ch_q;

    entry_t            buf_q [2];
    logic              wr_ptr_q, wr_ptr_d;
    logic              rd_ptr_q, rd_ptr_d;
    logic [1:0]        occ_q, occ_d;

    logic [WORD_SIZE-1:0] fifo_word [N_CH];
    logic              push;
    logic              pop;
    logic [2:0]        credit_lvl;
    logic              credit_ok;
    logic              rr_found;
    logic [CH_W-1:0]   rr_pick;
    int unsigned       rr_idx;
    entry_t            head;

    for (genvar k = 0; k < N_CH; k++) begin : g_unpack
        assign fifo_word[k] = i_fifo_data[k*WORD_SIZE +: WORD_SIZE];
    end

    assign push = rd_pend_q;
    assign pop  = o_valid & i_ready;

    // A read may only start if its word is guaranteed a buffer slot when it lands.
    always_comb begin
        credit_lvl = {1'b0, occ_q} + {2'b00, rd_pend_q} - {2'b00, pop};
        credit_ok  = (credit_lvl <= 3'd1);
    end

    always_comb begin
        rr_found = 1'b0;
        rr_pick  = '0;
        rr_idx   = 0;
        for (int i = 1; i <= N_CH; i++) begin
            rr_idx = int'(last_grant_q) + i;
            if (rr_idx >= N_CH) begin
                rr_idx = rr_idx - N_CH;
            end
            if (!rr_found && i_fifo_not_empty[CH_W'(rr_idx)]) begin
                rr_found = 1'b1;
                rr_pick  = CH_W'(rr_idx);
            end
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        burst_cnt_d  = burst_cnt_q;
        o_fifo_re    = '0;

        case (state_q)
            ST_IDLE: begin
                if (rr_found) begin
                    grant_d     = rr_pick;
                    burst_cnt_d = '0;
                    state_d     = ST_GRANT;
                end
            end
            ST_GRANT: begin
                if (i_fifo_not_empty[grant_q] && credit_ok && !rd_pend_q) begin
                    o_fifo_re[grant_q] = 1'b1;
                    burst_cnt_d        = burst_cnt_q + CNT_W'(1);
                end
                // not_empty is only trustworthy once the previous read has settled.
                if ((burst_cnt_d == CNT_W'(BURST_LEN)) ||
                    (!i_fifo_not_empty[grant_q] && !rd_pend_q)) begin
                    state_d      = ST_IDLE;
                    last_grant_d = grant_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q      <= ST_IDLE;
            grant_q      <= '0;
            last_grant_q <= CH_W'(N_CH - 1);
            burst_cnt_q  <= '0;
            rd_pend_q    <= 1'b0;
            rd_ch_q      <= '0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            burst_cnt_q  <= burst_cnt_d;
            rd_pend_q    <= |o_fifo_re;
            if (|o_fifo_re) begin
                rd_ch_q <= grant_q;
            end
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        if (push) begin
            wr_ptr_d = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        case ({push, pop})
            2'b10:   occ_d = occ_q + 2'd1;
            2'b01:   occ_d = occ_q - 2'd1;
            default: occ_d = occ_q;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            // NOTE: the two buffer entries are reset because the head drives o_data, which must read 0 after reset.
            buf_q[0] <= '0;
            buf_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            occ_q    <= 2'd0;
        end else begin
            if (push) begin
                buf_q[wr_ptr_q] <= '{ch: rd_ch_q, data: fifo_word[rd_ch_q]};
            end
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
        end
    end

    assign head    = buf_q[rd_ptr_q];
    assign o_valid = (occ_q != 2'd0);
    assign o_data  = head.data;
    assign o_ch    = head.ch;
    assign o_busy  = (state_q == ST_GRANT) | rd_pend_q | (occ_q != 2'd0);

`ifdef YA_FIFO_ARB_CNT_EN
    logic [15:0] word_cnt_q [N_CH];

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            for (int k = 0; k < N_CH; k++) begin
                word_cnt_q[k] <= '0;
            end
        end else if (pop) begin
            word_cnt_q[o_ch] <= word_cnt_q[o_ch] + 16'd1;
        end
    end

    for (genvar k = 0; k < N_CH; k++) begin : g_cnt_out
        assign o_word_cnt[k*16 +: 16] = word_cnt_q[k];
    end
`endif

    a_re_onehot: assert property (@(posedge i_clk) disable iff (!i_reset) $onehot0(o_fifo_re));
    a_no_overflow: assert property (@(posedge i_clk) disable iff (!i_reset)
        !(push && !pop && (occ_q == 2'd2)));

endmodule

// File: tb/tb_ya_fifo_rr_drain_arbiter.sv
// Randomized and directed bench for ya_fifo_rr_drain_arbiter against queue-based FIFO/scoreboard model.
// Define YA_FIFO_ARB_CNT_EN to also check the per-channel word counters.
module tb_ya_fifo_rr_drain_arbiter;

    localparam int N_CH      = 4;
    localparam int WORD_SIZE = 8;
    localparam int BURST_LEN = 4;
    localparam int CH_W      = 2;
    localparam int DEPTH     = 256;

    logic                      clk       = 1'b0;
    logic                      rst_n     = 1'b1;
    logic [N_CH-1:0]           fifo_ne   = '0;
    logic [N_CH-1:0]           fifo_re;
    logic [N_CH*WORD_SIZE-1:0] fifo_data = '0;
    logic                      dut_valid;
    logic                      ready     = 1'b0;
    logic [WORD_SIZE-1:0]      dut_data;
    logic [CH_W-1:0]           dut_ch;
    logic                      dut_busy;
`ifdef YA_FIFO_ARB_CNT_EN
    logic [N_CH*16-1:0]        word_cnt;
`endif

    always #5 clk = ~clk;

    ya_fifo_rr_drain_arbiter #(
        .N_CH      (N_CH),
        .WORD_SIZE (WORD_SIZE),
        .BURST_LEN (BURST_LEN)
    ) dut (
        .i_clk            (clk),
        .i_reset          (rst_n),
        .i_fifo_not_empty (fifo_ne),
        .o_fifo_re        (fifo_re),
        .i_fifo_data      (fifo_data),
        .o_valid          (dut_valid),
        .i_ready          (ready),
        .o_data           (dut_data),
        .o_ch             (dut_ch),
        .o_busy           (dut_busy)
`ifdef YA_FIFO_ARB_CNT_EN
        ,
        .o_word_cnt       (word_cnt)
`endif
    );

    // Each channel is a list of loaded words with a FIFO read index and a consumer index.
    logic [WORD_SIZE-1:0] mem [N_CH][DEPTH];
    int                   ld_cnt  [N_CH];
    int                   rd_idx  [N_CH];
    int                   pop_idx [N_CH];
    logic [WORD_SIZE-1:0] fdata   [N_CH];

    logic [N_CH-1:0]         re_now  = '0;
    logic [N_CH-1:0]         prev_re = '0;
    logic                    pop_now = 1'b0;
    int                      pop_ch_now;
    logic                    prev_stall = 1'b0;
    logic [CH_W+WORD_SIZE-1:0] prev_word;
    logic                    ready_req  = 1'b0;
    logic                    rand_ready = 1'b0;

    int n_checks = 0;
    int n_pass   = 0;
    int re_cnt   = 0;
    int n_pop    = 0;
    int log_ch [1024];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic load(input int ch, input logic [WORD_SIZE-1:0] w);
        if (ld_cnt[ch] < DEPTH) begin
            mem[ch][ld_cnt[ch]] = w;
            ld_cnt[ch]++;
        end
    endtask

    task automatic update_pins();
        for (int k = 0; k < N_CH; k++) begin
            fifo_ne[k] = (rd_idx[k] < ld_cnt[k]);
            fifo_data[k*WORD_SIZE +: WORD_SIZE] = fdata[k];
        end
    endtask

    task automatic model_clear();
        for (int k = 0; k < N_CH; k++) begin
            ld_cnt[k]  = 0;
            rd_idx[k]  = 0;
            pop_idx[k] = 0;
        end
        update_pins();
    endtask

    function automatic bit all_consumed();
        for (int k = 0; k < N_CH; k++) begin
            if (pop_idx[k] != ld_cnt[k]) return 1'b0;
        end
        return 1'b1;
    endfunction

    // Sampled on the falling edge, where all DUT outputs are settled.
    task automatic observe();
        re_now     = fifo_re;
        pop_now    = dut_valid & ready;
        pop_ch_now = int'(dut_ch);
        if (re_now != '0) begin
            re_cnt++;
            check("re_onehot", 32'($onehot0(re_now)), 32'd1);
            check("re_nonempty", 32'(|(re_now & fifo_ne)), 32'd1);
            check("re_back2back", 32'(|(re_now & prev_re)), 32'd0);
        end
        if (prev_stall) begin
            check("hold_valid", 32'(dut_valid), 32'd1);
            check("hold_word", 32'({dut_ch, dut_data}), 32'(prev_word));
        end
        if (pop_now) begin
            check("pop_avail", 32'(pop_idx[pop_ch_now] < rd_idx[pop_ch_now]), 32'd1);
            check("pop_data", 32'(dut_data), 32'(mem[pop_ch_now][pop_idx[pop_ch_now] % DEPTH]));
            if (n_pop < 1024) log_ch[n_pop] = pop_ch_now;
            n_pop++;
        end
        prev_re    = re_now;
        prev_stall = dut_valid & !ready;
        prev_word  = {dut_ch, dut_data};
    endtask

    // Applies what the DUT did at the rising edge to the FIFO model and the scoreboard.
    task automatic commit();
        for (int k = 0; k < N_CH; k++) begin
            if (re_now[k] && (rd_idx[k] < ld_cnt[k])) begin
                fdata[k] = mem[k][rd_idx[k]];
                rd_idx[k]++;
            end
        end
        if (pop_now) pop_idx[pop_ch_now]++;
        if (rand_ready) ready = ($urandom_range(0, 9) < 7);
        else ready = ready_req;
        update_pins();
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        commit();
        @(negedge clk);
        observe();
    endtask

    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        #1;
        check({tag, "_valid"}, 32'(dut_valid), 32'd0);
        check({tag, "_re"}, 32'(fifo_re), 32'd0);
        check({tag, "_data"}, 32'(dut_data), 32'd0);
        check({tag, "_ch"}, 32'(dut_ch), 32'd0);
        check({tag, "_busy"}, 32'(dut_busy), 32'd0);
        re_now     = '0;
        pop_now    = 1'b0;
        prev_re    = '0;
        prev_stall = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        // Words already read or buffered are lost by the reset.
        for (int k = 0; k < N_CH; k++) pop_idx[k] = rd_idx[k];
        update_pins();
        rst_n = 1'b1;
        observe();
    endtask

    task automatic drain(input string tag, input int budget);
        bit done;
        rand_ready = 1'b0;
        ready_req  = 1'b1;
        done       = 1'b0;
        for (int i = 0; i < budget && !done; i++) begin
            step();
            done = all_consumed() && !dut_busy;
        end
        check(tag, 32'(done), 32'd1);
    endtask

    initial begin
        int exp4 [5];
        int rem;
        int total;

        for (int k = 0; k < N_CH; k++) fdata[k] = '0;
        #1;
        do_reset("rst0");
        model_clear();

        // Single word: latency and tagging.
        ready_req = 1'b1;
        step();
        re_cnt = 0;
        load(2, 8'hA5);
        step(); check("s1_c0_valid", 32'(dut_valid), 32'd0);
        step(); check("s1_c1_re", 32'(fifo_re), 32'h4);
        step(); check("s1_c2_valid", 32'(dut_valid), 32'd0);
        step();
        check("s1_c3_valid", 32'(dut_valid), 32'd1);
        check("s1_c3_data", 32'(dut_data), 32'hA5);
        check("s1_c3_ch", 32'(dut_ch), 32'd2);
        step(); check("s1_c4_busy", 32'(dut_busy), 32'd0);
        check("s1_re_cnt", 32'(re_cnt), 32'd1);

        // All channels full: strict round-robin bursts.
        do_reset("rst2");
        model_clear();
        n_pop = 0;
        for (int k = 0; k < N_CH; k++)
            for (int w = 0; w < 8; w++) load(k, 8'($urandom));
        drain("s2_drain", 400);
        check("s2_count", 32'(n_pop), 32'd32);
        for (int p = 0; p < 32; p++) check("s2_order", 32'(log_ch[p]), 32'((p / BURST_LEN) % N_CH));
`ifdef YA_FIFO_ARB_CNT_EN
        for (int k = 0; k < N_CH; k++) check("s2_word_cnt", 32'(word_cnt[k*16 +: 16]), 32'd8);
`endif

        // Backpressure: the credit rule caps outstanding reads at the buffer depth.
        do_reset("rst3");
        model_clear();
        n_pop     = 0;
        ready_req = 1'b0;
        for (int w = 0; w < 10; w++) load(0, 8'($urandom));
        re_cnt = 0;
        repeat (20) step();
        check("s3_re_cnt", 32'(re_cnt), 32'd2);
        check("s3_valid", 32'(dut_valid), 32'd1);
        check("s3_head", 32'(dut_data), 32'(mem[0][0]));
        check("s3_ch", 32'(dut_ch), 32'd0);
        drain("s3_drain", 200);
        check("s3_count", 32'(n_pop), 32'd10);

        // Early release when the granted channel runs dry.
        do_reset("rst4");
        model_clear();
        n_pop = 0;
        for (int w = 0; w < 2; w++) load(1, 8'($urandom));
        for (int w = 0; w < 3; w++) load(3, 8'($urandom));
        drain("s4_drain", 200);
        check("s4_count", 32'(n_pop), 32'd5);
        exp4 = '{1, 1, 3, 3, 3};
        for (int p = 0; p < 5; p++) check("s4_order", 32'(log_ch[p]), 32'(exp4[p]));

        // Reset with a read in flight, then round-robin restarts from channel 0.
        do_reset("rst5a");
        model_clear();
        for (int w = 0; w < 8; w++) load(1, 8'($urandom));
        for (int w = 0; w < 8; w++) load(2, 8'($urandom));
        ready_req = 1'b1;
        re_cnt    = 0;
        for (int i = 0; i < 40 && re_cnt < 2; i++) step();
        check("s5_two_reads", 32'(re_cnt), 32'd2);
        step();
        check("s5_busy_pre", 32'(dut_busy), 32'd1);
        do_reset("s5_rst");
        rem = 0;
        for (int k = 0; k < N_CH; k++) rem += ld_cnt[k] - rd_idx[k];
        n_pop = 0;
        drain("s5_drain", 400);
        check("s5_first_ch", 32'(log_ch[0]), 32'd1);
        check("s5_count", 32'(n_pop), 32'(rem));

        // Random refills and random backpressure.
        do_reset("rst6");
        model_clear();
        n_pop      = 0;
        rand_ready = 1'b1;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 2) == 0) load(int'($urandom_range(0, N_CH - 1)), 8'($urandom));
            step();
        end
        drain("s6_drain", 3000);
        total = 0;
        for (int k = 0; k < N_CH; k++) total += ld_cnt[k];
        check("s6_count", 32'(n_pop), 32'(total));
        check("s6_busy", 32'(dut_busy), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
